// File: rtl/lid_rx_shell.sv
// ---------------------------------------------------------------------------
// lid_rx_shell
//
// Receiver end of a latency-insensitive channel. The upstream sender runs a
// credit scheme driven by o_ready and may still launch up to
// ROUND_TRIP_LATENCY tokens after it sees o_ready low. Those in-flight tokens
// land in a skid FIFO. Void tokens are dropped. Informative tokens are
// presented to the downstream core with a valid/ready handshake.
//
// Ports
//   clock             in   posedge clock
//   reset             in   asynchronous, active-low; clears all state
//   i_valid           in   upstream channel strobe
//   i_top_data_valid  in   1 = informative token, 0 = void token
//   i_top_data_data   in   token payload (signed, DATA_WIDTH)
//   o_ready           out  registered credit/ready to the sender
//   o_valid           out  FIFO head present to the core
//   o_top_data_valid  out  same as o_valid (voids are never stored)
//   o_top_data_data   out  payload at FIFO head
//   i_ready           in   core accepts the head this cycle
//   o_count           out  current occupancy
//   o_overflow        out  sticky; a token arrived while the FIFO was full
// ---------------------------------------------------------------------------
module lid_rx_shell #(
    parameter int DATA_WIDTH         = 16,
    parameter int N_STAGES           = 1,
    parameter int ROUND_TRIP_LATENCY = 2 * N_STAGES,
    parameter int DEPTH              = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_valid,
    input  logic                         i_top_data_valid,
    input  logic signed [DATA_WIDTH-1:0] i_top_data_data,
    output logic                         o_ready,
    output logic                         o_valid,
    output logic                         o_top_data_valid,
    output logic signed [DATA_WIDTH-1:0] o_top_data_data,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_OCC  = CNT_W'(DEPTH);

    // The FIFO must be able to swallow every token still in flight once the
    // sender has seen o_ready drop; anything shallower can overflow legally.
    if (DEPTH <= ROUND_TRIP_LATENCY) begin : g_depth_check
        $error("lid_rx_shell: DEPTH must exceed ROUND_TRIP_LATENCY");
    end

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             occ_q, occ_d;
    logic                         ready_q, ready_d;
    logic                         ovf_q, ovf_d;

    logic token;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        token = i_valid & i_top_data_valid;
        full  = (occ_q == FULL_OCC);
        pop   = (occ_q != '0) & i_ready;
        // Push is deliberately not gated by o_ready: the sender's credit rule
        // bounds traffic, so a token arriving with o_ready low is legitimate.
        push  = token & (~full | pop);

        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - CNT_W'(1);
        end

        // Explicit wrap so that non-power-of-two depths work.
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        // Credit looks ahead at next occupancy so the sender is throttled
        // early enough for its in-flight tokens to still fit.
        ready_d = ((32'(occ_d) + ROUND_TRIP_LATENCY) < DEPTH);

        ovf_d = ovf_q | (token & full & ~pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_top_data_data;
        end
    end

    // All outputs come straight from registered state; there is no bypass
    // from the input to the head.
    assign o_ready          = ready_q;
    assign o_valid          = (occ_q != '0);
    assign o_top_data_valid = (occ_q != '0);
    assign o_top_data_data  = mem_q[rd_ptr_q];
    assign o_count          = occ_q;
    assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_lid_rx_shell.sv
module tb_lid_rx_shell;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_top_data_valid;
    logic [15:0] i_top_data_data;
    logic        o_ready;
    logic        o_valid;
    logic        o_top_data_valid;
    logic [15:0] o_top_data_data;
    logic        i_ready;
    logic [3:0]  o_count;
    logic        o_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int t5_tdv [7] = '{0, 1, 0, 0, 1, 0, 1};
    int t5_dat [7] = '{17, 5, 18, 19, 6, 20, 7};
    int t5_cnt [7] = '{0, 1, 1, 1, 2, 2, 3};

    lid_rx_shell #(
        .DATA_WIDTH(16),
        .N_STAGES(1),
        .ROUND_TRIP_LATENCY(2),
        .DEPTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i_valid(i_valid),
        .i_top_data_valid(i_top_data_valid),
        .i_top_data_data(i_top_data_data),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_top_data_valid(o_top_data_valid),
        .o_top_data_data(o_top_data_data),
        .i_ready(i_ready),
        .o_count(o_count),
        .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic tv, input logic [15:0] d, input logic rdy);
        i_valid          = v;
        i_top_data_valid = tv;
        i_top_data_data  = d;
        i_ready          = rdy;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #12;
        // Reset state
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_tvalid", 32'(o_top_data_valid), 32'd0);
        chk("rst_data", {16'h0, o_top_data_data}, 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        reset = 1'b1;
        tick();

        // Test 1: streaming pass-through, one cycle of latency
        for (int k = 0; k < 200; k++) begin
            drive(1'b1, 1'b1, 16'(k), 1'b1);
            tick();
            chk("t1_valid", 32'(o_valid), 32'd1);
            chk("t1_data", {16'h0, o_top_data_data}, 32'(k));
            chk("t1_count", 32'(o_count), 32'd1);
            chk("t1_ready", 32'(o_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t1_empty_valid", 32'(o_valid), 32'd0);
        chk("t1_empty_count", 32'(o_count), 32'd0);
        chk("t1_ovf", 32'(o_overflow), 32'd0);

        // Test 2: credit drop at occupancy 6, two in-flight tokens absorbed
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 16'(k), 1'b0);
            tick();
            chk("t2_fill_count", 32'(o_count), 32'(k + 1));
            chk("t2_fill_ready", 32'(o_ready), (k + 1 < 6) ? 32'd1 : 32'd0);
        end
        chk("t2_peak_ovf", 32'(o_overflow), 32'd0);
        chk("t2_peak_head", {16'h0, o_top_data_data}, 32'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("t2_drain_count", 32'(o_count), 32'(8 - j));
            chk("t2_drain_ready", 32'(o_ready), (j > 2) ? 32'd1 : 32'd0);
            if (j < 8) chk("t2_drain_head", {16'h0, o_top_data_data}, 32'(j));
        end
        chk("t2_drain_valid", 32'(o_valid), 32'd0);

        // Test 4: push and pop together while full
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 16'(20 + k), 1'b0);
            tick();
        end
        chk("t4_full_count", 32'(o_count), 32'd8);
        drive(1'b1, 1'b1, 16'd28, 1'b1);
        tick();
        chk("t4_pp1_count", 32'(o_count), 32'd8);
        chk("t4_pp1_head", {16'h0, o_top_data_data}, 32'd21);
        drive(1'b1, 1'b1, 16'd29, 1'b1);
        tick();
        chk("t4_pp2_count", 32'(o_count), 32'd8);
        chk("t4_pp2_head", {16'h0, o_top_data_data}, 32'd22);
        chk("t4_ovf", 32'(o_overflow), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("t4_drain_count", 32'(o_count), 32'(8 - j));
            if (j < 8) chk("t4_drain_head", {16'h0, o_top_data_data}, 32'(22 + j));
        end

        // Test 5: void tokens interleaved with data
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'(t5_tdv[k]), 16'(t5_dat[k]), 1'b0);
            tick();
            chk("t5_count", 32'(o_count), 32'(t5_cnt[k]));
        end
        chk("t5_ovf", 32'(o_overflow), 32'd0);
        chk("t5_head0", {16'h0, o_top_data_data}, 32'd5);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t5_head1", {16'h0, o_top_data_data}, 32'd6);
        tick();
        chk("t5_head2", {16'h0, o_top_data_data}, 32'd7);
        tick();
        chk("t5_empty", 32'(o_valid), 32'd0);

        // Test 3: overflow when full with no pop; voids while full are harmless
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 16'(10 + k), 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 16'h00aa, 1'b0);
        tick();
        chk("t3_void_full_ovf", 32'(o_overflow), 32'd0);
        chk("t3_void_full_count", 32'(o_count), 32'd8);
        drive(1'b1, 1'b1, 16'd99, 1'b0);
        tick();
        chk("t3_ovf_set", 32'(o_overflow), 32'd1);
        chk("t3_ovf_count", 32'(o_count), 32'd8);
        chk("t3_ovf_head", {16'h0, o_top_data_data}, 32'd10);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("t3_drain_count", 32'(o_count), 32'(8 - j));
            if (j < 8) chk("t3_drain_head", {16'h0, o_top_data_data}, 32'(10 + j));
        end
        chk("t3_ovf_sticky", 32'(o_overflow), 32'd1);

        // Test 6: asynchronous reset with occupancy 5
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 16'(40 + k), 1'b0);
            tick();
        end
        chk("t6_pre_count", 32'(o_count), 32'd5);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        reset = 1'b0;
        #1;
        chk("t6_rst_count", 32'(o_count), 32'd0);
        chk("t6_rst_valid", 32'(o_valid), 32'd0);
        chk("t6_rst_data", {16'h0, o_top_data_data}, 32'd0);
        chk("t6_rst_ready", 32'(o_ready), 32'd1);
        chk("t6_rst_ovf", 32'(o_overflow), 32'd0);
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b1, 16'h8001, 1'b0);
        tick();
        chk("t6_new_head", {16'h0, o_top_data_data}, 32'h8001);
        chk("t6_new_count", 32'(o_count), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t6_pop_count", 32'(o_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
